// File: rtl/mem_stage_access_unit.sv
// MEM stage: drives EX/MEM loads/stores over a req/ready handshake and stalls meanwhile.
// Define MEM_STAGE_TIMEOUT_EN to abort requests after TIMEOUT_CYCLES cycles without ready.
module mem_stage_access_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_ALUResult,
   input  logic [DATA_WIDTH-1:0] in_WriteData,
   input  logic [DATA_WIDTH-1:0] in_PC_4,
   input  logic [4:0]            in_WriteRegister,
   input  logic                  in_CtrlRegWrite,
   input  logic                  in_CtrlMemRead,
   input  logic                  in_CtrlMemWrite,
   input  logic                  in_CtrlALUOrMem,
   input  logic                  in_CtrlALUMemOrPC,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_Stall,
   output logic [DATA_WIDTH-1:0] out_ReadData,
   output logic [DATA_WIDTH-1:0] out_WBData,
   output logic [4:0]            out_WriteRegister,
   output logic                  out_CtrlRegWrite,
   output logic                  out_AlignErr,
   output logic                  out_MemError
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            r_state;
   logic                  r_req;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic w_access;
   logic w_mis;
   logic w_idle;
   logic w_start;

   assign w_access = in_CtrlMemRead | in_CtrlMemWrite;
   assign w_mis    = w_access & (in_ALUResult[1:0] != 2'b00);
   assign w_idle   = (r_state == S_IDLE);
   assign w_start  = w_idle & w_access & ~w_mis;

`ifdef MEM_STAGE_TIMEOUT_EN
   localparam logic [7:0] LP_TMAX = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_cnt;
   logic       r_err;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
         r_cnt   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
`ifdef MEM_STAGE_TIMEOUT_EN
         r_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_addr  <= in_ALUResult[ADDR_WIDTH-1:0];
                  r_wdata <= in_WriteData;
                  // read+write together resolves to a write
                  r_we    <= in_CtrlMemWrite;
`ifdef MEM_STAGE_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  if (!r_we) r_rdata <= mem_rdata;
                  r_req   <= 1'b0;
                  r_state <= S_DONE;
               end
`ifdef MEM_STAGE_TIMEOUT_EN
               else if (r_cnt == LP_TMAX) begin
                  r_rdata <= '0;
                  r_req   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
`endif
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req   = r_req;
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   assign out_Stall    = w_start | (r_state == S_REQ);
   assign out_AlignErr = w_idle & w_mis;
   assign out_ReadData = r_rdata;

   assign out_WBData = in_CtrlALUMemOrPC ? in_PC_4 :
                       in_CtrlALUOrMem   ? r_rdata : in_ALUResult;

   assign out_WriteRegister = in_WriteRegister;
   assign out_CtrlRegWrite  = in_CtrlRegWrite & ~out_AlignErr;

`ifdef MEM_STAGE_TIMEOUT_EN
   assign out_MemError = r_err;
`else
   assign out_MemError = 1'b0;
`endif

endmodule
